// File: rtl/cpu_run_pkg.sv
// Shared types and default constants for the CPU run controller.
// Imported by cpu_run_ctrl and anything that decodes its state.
package cpu_run_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RST,
    RUN,
    DONE
  } run_state_t;

  localparam int unsigned RUN_RST_CYCLES = 2;
  localparam int unsigned RUN_CW         = 16;
  localparam int unsigned RUN_TIMEOUT    = 1000;

endpackage

// File: rtl/cpu_run_ctrl.sv
// Run controller: holds the core in reset, releases it, then times
// the run until core_done or the watchdog ends it.
module cpu_run_ctrl
  import cpu_run_pkg::*;
#(
  parameter int unsigned RST_CYCLES = RUN_RST_CYCLES,
  parameter int unsigned CW         = RUN_CW,
  parameter int unsigned TIMEOUT    = RUN_TIMEOUT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          abort,
  input  logic          core_done,
  output logic          core_reset,
  output logic          core_req,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam int unsigned RW = $clog2(RST_CYCLES + 1);

  run_state_t    state_q, state_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] cyc_inc;
  logic          tmo_q, tmo_d;

  assign cyc_inc = cyc_q + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      cyc_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cyc_q   <= cyc_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    cyc_d   = cyc_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RST;
          rcnt_d  = RW'(RST_CYCLES - 1);
          cyc_d   = '0;
          tmo_d   = 1'b0;
        end
      end
      RST: begin
        if (abort) begin
          state_d = IDLE;
        end else if (rcnt_q == '0) begin
          state_d = RUN;
        end else begin
          rcnt_d = rcnt_q - RW'(1);
        end
      end
      RUN: begin
        // An aborted edge does not count as a run cycle.
        if (abort) begin
          state_d = IDLE;
        end else begin
          cyc_d = cyc_inc;
          if (core_done) begin
            state_d = DONE;
          end else if (cyc_inc == CW'(TIMEOUT)) begin
            state_d = DONE;
            tmo_d   = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign core_reset = (state_q != RUN);
  assign core_req   = (state_q == RUN) && (cyc_q == '0);
  assign busy       = (state_q == RST) || (state_q == RUN);
  assign finished   = (state_q == DONE);
  assign timeout    = tmo_q;
  assign cycles     = cyc_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Scoreboarded bench for cpu_run_ctrl with RST_CYCLES=2, TIMEOUT=8.
// Run results are queued at stimulus time and checked on finished.
module tb_cpu_run_ctrl;

  localparam int CW = 16;

  typedef struct packed {
    logic [CW-1:0] cyc;
    logic          tmo;
  } res_t;

  logic          clk;
  logic          reset;
  logic          start;
  logic          abort;
  logic          core_done;
  logic          core_reset;
  logic          core_req;
  logic          busy;
  logic          finished;
  logic          timeout;
  logic [CW-1:0] cycles;

  int   vectors = 0;
  int   errors  = 0;
  res_t sb_q[$];

  cpu_run_ctrl #(
    .RST_CYCLES(2),
    .CW        (CW),
    .TIMEOUT   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .core_done (core_done),
    .core_reset(core_reset),
    .core_req  (core_req),
    .busy      (busy),
    .finished  (finished),
    .timeout   (timeout),
    .cycles    (cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues start and leaves the bench in the first RUN cycle.
  task automatic start_run(input string tag);
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_rst1_busy"}, 32'(busy), 32'd1);
    chk({tag, "_rst1_crst"}, 32'(core_reset), 32'd1);
    chk({tag, "_rst1_tmo"}, 32'(timeout), 32'd0);
    step();
    chk({tag, "_rst2_crst"}, 32'(core_reset), 32'd1);
    chk({tag, "_rst2_req"}, 32'(core_req), 32'd0);
    step();
    chk({tag, "_run1_crst"}, 32'(core_reset), 32'd0);
    chk({tag, "_run1_req"}, 32'(core_req), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!reset && finished) begin
      if (sb_q.size() == 0) begin
        vectors++;
        errors++;
        $display("FAIL mon_unexpected_finished: cycles=%0d", cycles);
      end else begin
        res_t e;
        e = sb_q.pop_front();
        vectors++;
        if (cycles !== e.cyc) begin
          errors++;
          $display("FAIL mon_cycles: got %0d expected %0d", cycles, e.cyc);
        end
        vectors++;
        if (timeout !== e.tmo) begin
          errors++;
          $display("FAIL mon_timeout: got %0b expected %0b", timeout, e.tmo);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: sim did not finish");
    $fatal(1, "time limit");
  end

  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    core_done = 1'b0;
    #12;
    chk("rst_crst", 32'(core_reset), 32'd1);
    chk("rst_req", 32'(core_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_fin", 32'(finished), 32'd0);
    chk("rst_tmo", 32'(timeout), 32'd0);
    chk("rst_cyc", 32'(cycles), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step();

    // Normal run, done in 5th RUN cycle
    start_run("norm");
    step();
    chk("norm_req_off", 32'(core_req), 32'd0);
    chk("norm_cyc1", 32'(cycles), 32'd1);
    repeat (3) step();
    core_done = 1'b1;
    sb_q.push_back('{cyc: 16'd5, tmo: 1'b0});
    step();
    core_done = 1'b0;
    chk("norm_fin", 32'(finished), 32'd1);
    chk("norm_busy", 32'(busy), 32'd0);
    chk("norm_crst", 32'(core_reset), 32'd1);
    step();
    chk("norm_fin_off", 32'(finished), 32'd0);
    chk("norm_cyc_hold", 32'(cycles), 32'd5);
    step();

    // Watchdog
    start_run("wdog");
    sb_q.push_back('{cyc: 16'd8, tmo: 1'b1});
    repeat (8) step();
    chk("wdog_fin", 32'(finished), 32'd1);
    chk("wdog_tmo", 32'(timeout), 32'd1);
    chk("wdog_cyc", 32'(cycles), 32'd8);
    step();
    chk("wdog_tmo_sticky", 32'(timeout), 32'd1);

    // Done/timeout tie; start_run checks timeout cleared
    start_run("tie");
    repeat (7) step();
    core_done = 1'b1;
    sb_q.push_back('{cyc: 16'd8, tmo: 1'b0});
    step();
    core_done = 1'b0;
    chk("tie_tmo", 32'(timeout), 32'd0);
    chk("tie_cyc", 32'(cycles), 32'd8);
    step();

    // Abort in 3rd RUN cycle
    start_run("abrun");
    repeat (2) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abrun_busy", 32'(busy), 32'd0);
    chk("abrun_crst", 32'(core_reset), 32'd1);
    chk("abrun_fin", 32'(finished), 32'd0);
    chk("abrun_cyc", 32'(cycles), 32'd2);
    repeat (2) step();

    // Abort during RST
    start = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("abrst_busy", 32'(busy), 32'd0);
    chk("abrst_cyc", 32'(cycles), 32'd0);
    repeat (3) step();
    chk("abrst_idle", 32'(busy), 32'd0);

    // Start toggled while busy has no effect
    start_run("tog");
    start = 1'b1;
    step();
    chk("tog_cyc1", 32'(cycles), 32'd1);
    chk("tog_busy", 32'(busy), 32'd1);
    start = 1'b0;
    step();
    chk("tog_cyc2", 32'(cycles), 32'd2);
    core_done = 1'b1;
    sb_q.push_back('{cyc: 16'd3, tmo: 1'b0});
    step();
    core_done = 1'b0;
    step();

    // Back-to-back minimum runs with start held
    start = 1'b1;
    core_done = 1'b1;
    step();
    step();
    step();
    chk("b2b_req1", 32'(core_req), 32'd1);
    sb_q.push_back('{cyc: 16'd1, tmo: 1'b0});
    step();
    chk("b2b_fin1", 32'(finished), 32'd1);
    step();
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    step();
    chk("b2b_rst_busy", 32'(busy), 32'd1);
    chk("b2b_rst_crst", 32'(core_reset), 32'd1);
    chk("b2b_rst_cyc", 32'(cycles), 32'd0);
    start = 1'b0;
    step();
    step();
    chk("b2b_req2", 32'(core_req), 32'd1);
    sb_q.push_back('{cyc: 16'd1, tmo: 1'b0});
    step();
    core_done = 1'b0;
    chk("b2b_fin2", 32'(finished), 32'd1);
    step();

    // Asynchronous reset mid-run
    start_run("arst");
    repeat (3) step();
    #2;
    reset = 1'b1;
    #1;
    chk("arst_crst", 32'(core_reset), 32'd1);
    chk("arst_req", 32'(core_req), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cyc", 32'(cycles), 32'd0);
    chk("arst_tmo", 32'(timeout), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) step();
    chk("arst_stay_idle", 32'(busy), 32'd0);

    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Run controller sitting directly upstream of the processor top level. It accepts a start request from the host or testbench and holds the core in reset for a fixed number of cycles. It then releases the core, drives the core's `req`, and counts cycles until the core raises `done` or a watchdog expires. It reports busy, completion, timeout and the measured cycle count.

## Interface

**Parameters**
- `RST_CYCLES`, default 2: cycles `core_reset` is held after a start is accepted; must be ≥ 1.
- `CW`, default 16: width of the cycle counter.
- `TIMEOUT`, default 1000: RUN-cycle limit before the watchdog fires; must satisfy 1 ≤ TIMEOUT < 2^CW.

**Ports**
- `clk`  in  1  system clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; forces the reset state immediately.
- `start`  in  1  level; sampled only in IDLE.
- `abort`  in  1  level; sampled only in RST and RUN.
- `core_done`  in  1  the processor's `done` output.
- `core_reset`  out  1  drives the processor's `reset`.
- `core_req`  out  1  drives the processor's `req`.
- `busy`  out  1  high in RST and RUN.
- `finished`  out  1  one-cycle pulse in DONE.
- `timeout`  out  1  sticky watchdog flag.
- `cycles`  out  CW  RUN-cycle count of the last or current run.

## Operation

**Reset state:** state=IDLE, `core_reset`=1, `core_req`=0, `busy`=0, `finished`=0, `timeout`=0, `cycles`=0, reset counter=0.

**State machine:** states IDLE, RST, RUN, DONE. All outputs are decoded from registered state and counters.
- **IDLE:** `core_reset`=1. If `start`=1, go to RST, load the reset counter with RST_CYCLES-1, clear `cycles` to 0, clear `timeout`.
- **RST:** `core_reset`=1, `busy`=1, `core_req`=0. Decrement the counter each cycle. When counter=0, go to RUN. `core_done` is ignored.
- **RUN:** `core_reset`=0, `busy`=1. `core_req`=1 only while `cycles`=0, i.e. the first RUN cycle. Each RUN edge sets `cycles` ← `cycles`+1. Next state, in priority order:
  1. `abort` → IDLE, and `cycles` is not incremented on that edge;
  2. `core_done` → DONE;
  3. `cycles`+1 = TIMEOUT → DONE and set `timeout`=1;
  4. otherwise stay in RUN.
- **DONE:** `finished`=1, `core_reset`=1, `busy`=0. Unconditionally go to IDLE next cycle.

**Boundary rules**
- `abort` in RST → IDLE next cycle. No `finished` pulse. `timeout` and `cycles` are left as they are.
- `core_done` and watchdog expiry on the same edge → done wins. `timeout` stays 0 and `cycles`=TIMEOUT.
- `start` asserted outside IDLE is ignored.
- `start` held high through DONE→IDLE starts a new run on the next edge, giving back-to-back runs.
- `cycles` holds its final value from DONE until the next start is accepted.
- `cycles` never wraps, because TIMEOUT < 2^CW bounds it.
- Asserting `reset` mid-run returns to the reset state immediately, with no clock edge needed. Because `core_reset`=1 in that state, the core is also held.

## Timing

- Start accepted at edge E0 → RST during cycles E0..E0+RST_CYCLES-1.
- First RUN cycle begins at edge E0+RST_CYCLES; `core_req` is high for exactly that cycle.
- `core_done` sampled high in the k-th RUN cycle → DONE in the next cycle with `cycles`=k. `finished` is high for one cycle, then IDLE.
- Start-to-`finished` latency = RST_CYCLES + k cycles.
- Minimum run is k=1: `core_done` high in the first RUN cycle.
- No combinational path from any input to any output.

## Structure

- Package `cpu_run_pkg` holds:
  - `typedef enum logic [1:0] {IDLE, RST, RUN, DONE} run_state_t`;
  - default constants `RUN_RST_CYCLES`=2, `RUN_CW`=16, `RUN_TIMEOUT`=1000.
- Single module with no sub-modules: one state register, one reset down-counter of width $clog2(RST_CYCLES+1), one CW-bit up-counter and the sticky `timeout` flop. Output decode is combinational from these registers.

## Test plan

- **Normal run:** RST_CYCLES=2; pulse `start` at E0 → `core_reset`=1 for 2 cycles, `core_req` pulse at E0+2. Raise `core_done` in the 5th RUN cycle → `cycles`=5, single `finished` pulse, `busy`=0, `timeout`=0.
- **Watchdog:** TIMEOUT=8 and `core_done` held 0 → after 8 RUN cycles `timeout`=1, `cycles`=8, one `finished` pulse. The next accepted `start` clears `timeout` to 0.
- **Done/timeout tie:** TIMEOUT=8; raise `core_done` in the 8th RUN cycle → `timeout`=0, `cycles`=8.
- **Abort:** assert `abort` in the 3rd RUN cycle → IDLE next cycle, `cycles`=2, no `finished`, `core_reset`=1. Repeat with `abort` during RST → IDLE, `cycles`=0.
- **Async reset:** assert `reset` between edges mid-RUN → immediately `core_reset`=1, `core_req`=0, `busy`=0, `cycles`=0, `timeout`=0.
- **Start handling:** hold `start` high continuously → back-to-back runs, each preceded by RST_CYCLES of `core_reset`. `start` toggled while busy → no effect on state or counters.
